vga_span_address_gen: RTL and testbench
=======================================

Name: vga_span_address_gen

Overview:
- Sequential successor to the combinational coordinate-to-address translator.
- Accepts a horizontal pixel run request (x, y, length) through a valid/ready handshake.
- Emits one frame-buffer address per pixel as a valid/ready stream, clipped to the configured screen.
- Sits between drawing engines (sprite/line/rect fill) and the VGA adapter's video memory write port.
- Resolution is any H_RES x V_RES, not restricted to fixed 320x240/640x480 modes.

Parameters:
- H_RES, 320, screen width in pixels (1..1024).
- V_RES, 240, screen height in pixels (1..1024).
- X_W, 9, width of x coordinate; must hold H_RES-1.
- Y_W, 8, width of y coordinate; must hold V_RES-1.
- LEN_W, 9, width of run-length field.
- ADDR_W, 17, width of memory address; must hold H_RES*V_RES-1.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  run request valid.
- req_ready  out  1  block can accept a request.
- req_x  in  X_W  start x (unsigned).
- req_y  in  Y_W  row y (unsigned).
- req_len  in  LEN_W  pixel count; 0 treated as 1.
- addr_valid  out  1  output address valid.
- addr_ready  in  1  consumer accepts address.
- addr  out  ADDR_W  y*H_RES + x for current pixel.
- addr_x  out  X_W  x of current pixel.
- addr_last  out  1  current pixel is the final pixel of the run.
- clipped  out  1  one-cycle pulse: request truncated or dropped.

Behaviour:
- Reset (async, active-high): state=IDLE; req_ready=0 while reset asserted, 1 on first cycle after release. addr_valid=0, addr=0, addr_x=0, addr_last=0, clipped=0. Reset mid-run abandons the run with no further outputs.
- Handshakes: request accepted when req_valid & req_ready. Address transferred when addr_valid & addr_ready. addr, addr_x, addr_last stable while addr_valid & !addr_ready.
- IDLE: req_ready=1; addr_valid=0. On accept, latch inputs; eff_len = (req_len==0) ? 1 : req_len.
  - req_x >= H_RES or req_y >= V_RES: drop request; clipped=1 next cycle; stay IDLE.
  - Otherwise go to CALC.
- CALC (1 cycle): req_ready=0.
  - base = y*H_RES + x, computed at full ADDR_W unsigned, zero-extended operands.
  - count = min(eff_len, H_RES - x).
  - clipped=1 this cycle if eff_len > H_RES - x.
  - Go to EMIT.
- EMIT: addr_valid=1; addr_last = (count==1).
  - On transfer: addr+=1, addr_x+=1, count-=1.
  - On transfer with count==1: go to IDLE; addr_valid=0 next cycle.
- Latency: accept in cycle N -> first addr_valid in cycle N+2. Throughput: 1 address/cycle when addr_ready held high.
- Next request can be accepted the cycle after the last transfer; no overlap between runs.
- Runs never wrap to the next row; truncation at the right edge only.
- Address arithmetic never exceeds H_RES*V_RES-1.

Test Plan:
- Defaults. Req x=5, y=2, len=3, addr_ready=1 -> addrs 645, 646, 647 on cycles N+2..N+4; addr_last only on 647; clipped=0.
- Right-edge truncation. x=318, y=0, len=10 -> addrs 318, 319 only, last on 319; clipped pulses in CALC cycle.
- Out-of-range drop. y=240 (defaults) -> no addr_valid ever; clipped pulse at N+1; req_ready back high at N+1. Repeat with x=320.
- Backpressure. x=0, y=1, len=4; toggle addr_ready 1,0,0,1,1,0,1 -> addrs 320..323 in order, each held stable while stalled, no duplicates or skips.
- Generalised resolution. H_RES=640, V_RES=480, X_W=10, Y_W=9, ADDR_W=19. Req x=639, y=479, len=0 -> single addr 307199 with addr_last=1. Also H_RES=100, V_RES=75: x=10, y=3, len=2 -> 310, 311.
- Reset mid-run. Assert reset during EMIT of len=8 run after 3 transfers -> addr_valid drops immediately (async). After release, req_ready=1 and a new req x=1, y=0, len=1 yields addr 1.

Source files
------------

// File: rtl/vga_span_address_gen.sv
// Turns a horizontal pixel run request (x, y, length) into a stream of
// frame-buffer addresses, one per pixel, clipped at the right screen edge.
module vga_span_address_gen #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int LEN_W  = 9,
    parameter int ADDR_W = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [X_W-1:0]    req_x,
    input  logic [Y_W-1:0]    req_y,
    input  logic [LEN_W-1:0]  req_len,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr,
    output logic [X_W-1:0]    addr_x,
    output logic              addr_last,
    output logic              clipped
);

    // Count must hold both the requested length and the full row width.
    localparam int CNT_W = (LEN_W > X_W + 1) ? LEN_W : X_W + 1;

    localparam logic [X_W:0]        H_LIM_C  = (X_W + 1)'(H_RES);
    localparam logic [Y_W:0]        V_LIM_C  = (Y_W + 1)'(V_RES);
    localparam logic [CNT_W-1:0]    H_CNT_C  = CNT_W'(H_RES);
    localparam logic [ADDR_W-1:0]   H_ADDR_C = ADDR_W'(H_RES);
    localparam logic [CNT_W-1:0]    ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    TWO_C    = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic                req_ready_r;
    logic                addr_valid_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [X_W-1:0]      addr_x_r;
    logic                addr_last_r;
    logic                clipped_r;

    logic [X_W-1:0]      x_r;
    logic [Y_W-1:0]      y_r;
    logic [CNT_W-1:0]    len_r;
    logic [CNT_W-1:0]    count_r;

    logic                accept_s;
    logic                xfer_s;
    logic                out_of_range_s;
    logic [CNT_W-1:0]    eff_len_s;
    logic [CNT_W-1:0]    space_s;
    logic [CNT_W-1:0]    lat_space_s;
    logic [CNT_W-1:0]    count_init_s;
    logic [ADDR_W-1:0]   base_s;

    assign accept_s = req_valid & req_ready_r;
    assign xfer_s   = addr_valid_r & addr_ready;

    // Request qualification on the live inputs and run setup on the latched ones.
    always_comb begin
        eff_len_s      = CNT_W'(req_len);
        out_of_range_s = ({1'b0, req_x} >= H_LIM_C) || ({1'b0, req_y} >= V_LIM_C);
        space_s        = H_CNT_C - CNT_W'(req_x);
        lat_space_s    = H_CNT_C - CNT_W'(x_r);
        count_init_s   = len_r;
        base_s         = (ADDR_W'(y_r) * H_ADDR_C) + ADDR_W'(x_r);
        if (req_len == {LEN_W{1'b0}}) begin
            eff_len_s = ONE_C;
        end else begin
            eff_len_s = CNT_W'(req_len);
        end
        if (len_r > lat_space_s) begin
            count_init_s = lat_space_s;
        end else begin
            count_init_s = len_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !out_of_range_s) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: state_s = EMIT;
            EMIT: begin
                if (xfer_s && (count_r == ONE_C)) begin
                    state_s = IDLE;
                end else begin
                    state_s = EMIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, clip pulse and address stream registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_ready_r  <= 1'b0;
            addr_valid_r <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            addr_x_r     <= {X_W{1'b0}};
            addr_last_r  <= 1'b0;
            clipped_r    <= 1'b0;
            x_r          <= {X_W{1'b0}};
            y_r          <= {Y_W{1'b0}};
            len_r        <= {CNT_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
        end else begin
            req_ready_r <= (state_s == IDLE);
            clipped_r   <= accept_s && (out_of_range_s || (eff_len_s > space_s));
            if (accept_s) begin
                x_r   <= req_x;
                y_r   <= req_y;
                len_r <= eff_len_s;
            end
            case (state_r)
                CALC: begin
                    addr_valid_r <= 1'b1;
                    addr_r       <= base_s;
                    addr_x_r     <= x_r;
                    count_r      <= count_init_s;
                    addr_last_r  <= (count_init_s == ONE_C);
                end
                EMIT: begin
                    if (xfer_s) begin
                        if (count_r == ONE_C) begin
                            addr_valid_r <= 1'b0;
                            addr_last_r  <= 1'b0;
                        end else begin
                            addr_r      <= addr_r + ADDR_W'(1);
                            addr_x_r    <= addr_x_r + X_W'(1);
                            count_r     <= count_r - ONE_C;
                            addr_last_r <= (count_r == TWO_C);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign addr_valid = addr_valid_r;
    assign addr       = addr_r;
    assign addr_x     = addr_x_r;
    assign addr_last  = addr_last_r;
    assign clipped    = clipped_r;

endmodule

// File: tb/tb_vga_span_address_gen.sv
// Directed bench: default 320x240 instance plus 640x480 and 100x75 instances.
module tb_vga_span_address_gen;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int compares = 0;
    int errs     = 0;

    logic        req_valid, req_ready, addr_valid, addr_ready, addr_last, clipped;
    logic [8:0]  req_x, req_len, addr_x;
    logic [7:0]  req_y;
    logic [16:0] addr;

    logic        req_valid_b, req_ready_b, addr_valid_b, addr_ready_b, addr_last_b, clipped_b;
    logic [9:0]  req_x_b, req_len_b, addr_x_b;
    logic [8:0]  req_y_b;
    logic [18:0] addr_b;

    logic        req_valid_c, req_ready_c, addr_valid_c, addr_ready_c, addr_last_c, clipped_c;
    logic [6:0]  req_x_c, req_len_c, addr_x_c, req_y_c;
    logic [12:0] addr_c;

    vga_span_address_gen dut_a (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_len(req_len), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .addr(addr), .addr_x(addr_x), .addr_last(addr_last),
        .clipped(clipped)
    );

    vga_span_address_gen #(.H_RES(640), .V_RES(480), .X_W(10), .Y_W(9), .LEN_W(10), .ADDR_W(19)) dut_b (
        .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_x(req_x_b), .req_y(req_y_b), .req_len(req_len_b), .addr_valid(addr_valid_b),
        .addr_ready(addr_ready_b), .addr(addr_b), .addr_x(addr_x_b), .addr_last(addr_last_b),
        .clipped(clipped_b)
    );

    vga_span_address_gen #(.H_RES(100), .V_RES(75), .X_W(7), .Y_W(7), .LEN_W(7), .ADDR_W(13)) dut_c (
        .clock(clock), .reset(reset), .req_valid(req_valid_c), .req_ready(req_ready_c),
        .req_x(req_x_c), .req_y(req_y_c), .req_len(req_len_c), .addr_valid(addr_valid_c),
        .addr_ready(addr_ready_c), .addr(addr_c), .addr_x(addr_x_c), .addr_last(addr_last_c),
        .clipped(clipped_c)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_a(input logic [8:0] x, input logic [7:0] y, input logic [8:0] len);
        req_valid = 1'b1; req_x = x; req_y = y; req_len = len;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        compares++;
        if (req_ready !== 1'b0 || addr_valid !== 1'b0 || addr !== 17'd0 || addr_last !== 1'b0 || clipped !== 1'b0) begin
            errs++;
            $display("FAIL reset_outputs got rdy=%b v=%b a=%0d l=%b c=%b want 0 0 0 0 0", req_ready, addr_valid, addr, addr_last, clipped);
        end
        step();
        reset = 1'b0;
        step();
        compares++;
        if (req_ready !== 1'b1 || req_ready_b !== 1'b1 || req_ready_c !== 1'b1) begin
            errs++;
            $display("FAIL reset_release_ready got %b%b%b want 111", req_ready, req_ready_b, req_ready_c);
        end
    endtask

    task automatic test_defaults();
        send_a(9'd5, 8'd2, 9'd3);
        compares++;
        if (addr_valid !== 1'b0 || req_ready !== 1'b0 || clipped !== 1'b0) begin
            errs++;
            $display("FAIL defaults_calc got v=%b rdy=%b c=%b want 0 0 0", addr_valid, req_ready, clipped);
        end
        step();
        compares++;
        if (addr_valid !== 1'b1 || addr !== 17'd645 || addr_x !== 9'd5 || addr_last !== 1'b0) begin
            errs++;
            $display("FAIL defaults_p0 got v=%b a=%0d x=%0d l=%b want 1 645 5 0", addr_valid, addr, addr_x, addr_last);
        end
        step();
        compares++;
        if (addr_valid !== 1'b1 || addr !== 17'd646 || addr_last !== 1'b0 || clipped !== 1'b0) begin
            errs++;
            $display("FAIL defaults_p1 got v=%b a=%0d l=%b c=%b want 1 646 0 0", addr_valid, addr, addr_last, clipped);
        end
        step();
        compares++;
        if (addr_valid !== 1'b1 || addr !== 17'd647 || addr_x !== 9'd7 || addr_last !== 1'b1) begin
            errs++;
            $display("FAIL defaults_p2 got v=%b a=%0d x=%0d l=%b want 1 647 7 1", addr_valid, addr, addr_x, addr_last);
        end
        step();
        compares++;
        if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin
            errs++;
            $display("FAIL defaults_done got v=%b rdy=%b want 0 1", addr_valid, req_ready);
        end
    endtask

    task automatic test_truncate();
        send_a(9'd318, 8'd0, 9'd10);
        compares++;
        if (clipped !== 1'b1 || addr_valid !== 1'b0) begin
            errs++;
            $display("FAIL trunc_clip got c=%b v=%b want 1 0", clipped, addr_valid);
        end
        step();
        compares++;
        if (addr_valid !== 1'b1 || addr !== 17'd318 || addr_last !== 1'b0 || clipped !== 1'b0) begin
            errs++;
            $display("FAIL trunc_p0 got v=%b a=%0d l=%b c=%b want 1 318 0 0", addr_valid, addr, addr_last, clipped);
        end
        step();
        compares++;
        if (addr_valid !== 1'b1 || addr !== 17'd319 || addr_x !== 9'd319 || addr_last !== 1'b1) begin
            errs++;
            $display("FAIL trunc_p1 got v=%b a=%0d x=%0d l=%b want 1 319 319 1", addr_valid, addr, addr_x, addr_last);
        end
        step();
        compares++;
        if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin
            errs++;
            $display("FAIL trunc_done got v=%b rdy=%b want 0 1", addr_valid, req_ready);
        end
    endtask

    task automatic test_drop(input logic [8:0] x, input logic [7:0] y);
        send_a(x, y, 9'd4);
        compares++;
        if (clipped !== 1'b1 || req_ready !== 1'b1 || addr_valid !== 1'b0) begin
            errs++;
            $display("FAIL drop_pulse x=%0d y=%0d got c=%b rdy=%b v=%b want 1 1 0", x, y, clipped, req_ready, addr_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            compares++;
            if (addr_valid !== 1'b0 || clipped !== 1'b0) begin
                errs++;
                $display("FAIL drop_quiet x=%0d y=%0d cyc=%0d got v=%b c=%b want 0 0", x, y, i, addr_valid, clipped);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat;
        int idx;
        int waited;
        pat = 7'b1011001;
        idx = 0;
        waited = 0;
        addr_ready = 1'b0;
        send_a(9'd0, 8'd1, 9'd4);
        while (addr_valid !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        compares++;
        if (addr_valid !== 1'b1) begin
            errs++;
            $display("FAIL bp_timeout got v=%b want 1", addr_valid);
        end
        for (int i = 0; i < 7; i++) begin
            addr_ready = pat[i];
            compares++;
            if (addr_valid !== 1'b1 || addr !== 17'(320 + idx) || addr_x !== 9'(idx) || addr_last !== (idx == 3)) begin
                errs++;
                $display("FAIL bp_cyc%0d got v=%b a=%0d x=%0d l=%b want 1 %0d %0d %b", i, addr_valid, addr, addr_x, addr_last, 320 + idx, idx, (idx == 3));
            end
            step();
            if (pat[i]) idx++;
        end
        addr_ready = 1'b1;
        compares++;
        if (addr_valid !== 1'b0 || idx != 4) begin
            errs++;
            $display("FAIL bp_end got v=%b n=%0d want 0 4", addr_valid, idx);
        end
    endtask

    task automatic test_resolutions();
        req_valid_b = 1'b1; req_x_b = 10'd639; req_y_b = 9'd479; req_len_b = 10'd0;
        req_valid_c = 1'b1; req_x_c = 7'd10; req_y_c = 7'd3; req_len_c = 7'd2;
        step();
        req_valid_b = 1'b0; req_valid_c = 1'b0;
        compares++;
        if (clipped_b !== 1'b0 || clipped_c !== 1'b0) begin
            errs++;
            $display("FAIL res_clip got b=%b c=%b want 0 0", clipped_b, clipped_c);
        end
        step();
        compares++;
        if (addr_valid_b !== 1'b1 || addr_b !== 19'd307199 || addr_x_b !== 10'd639 || addr_last_b !== 1'b1) begin
            errs++;
            $display("FAIL res640_p0 got v=%b a=%0d x=%0d l=%b want 1 307199 639 1", addr_valid_b, addr_b, addr_x_b, addr_last_b);
        end
        compares++;
        if (addr_valid_c !== 1'b1 || addr_c !== 13'd310 || addr_last_c !== 1'b0) begin
            errs++;
            $display("FAIL res100_p0 got v=%b a=%0d l=%b want 1 310 0", addr_valid_c, addr_c, addr_last_c);
        end
        step();
        compares++;
        if (addr_valid_b !== 1'b0 || req_ready_b !== 1'b1) begin
            errs++;
            $display("FAIL res640_done got v=%b rdy=%b want 0 1", addr_valid_b, req_ready_b);
        end
        compares++;
        if (addr_valid_c !== 1'b1 || addr_c !== 13'd311 || addr_x_c !== 7'd11 || addr_last_c !== 1'b1) begin
            errs++;
            $display("FAIL res100_p1 got v=%b a=%0d x=%0d l=%b want 1 311 11 1", addr_valid_c, addr_c, addr_x_c, addr_last_c);
        end
        step();
        compares++;
        if (addr_valid_c !== 1'b0) begin
            errs++;
            $display("FAIL res100_done got v=%b want 0", addr_valid_c);
        end
    endtask

    task automatic test_reset_midrun();
        send_a(9'd10, 8'd0, 9'd8);
        step();
        step();
        step();
        step();
        compares++;
        if (addr_valid !== 1'b1 || addr !== 17'd13) begin
            errs++;
            $display("FAIL midrun_pre got v=%b a=%0d want 1 13", addr_valid, addr);
        end
        reset = 1'b1;
        #1;
        compares++;
        if (addr_valid !== 1'b0 || req_ready !== 1'b0 || addr !== 17'd0) begin
            errs++;
            $display("FAIL midrun_async got v=%b rdy=%b a=%0d want 0 0 0", addr_valid, req_ready, addr);
        end
        step();
        reset = 1'b0;
        step();
        compares++;
        if (req_ready !== 1'b1 || addr_valid !== 1'b0) begin
            errs++;
            $display("FAIL midrun_release got rdy=%b v=%b want 1 0", req_ready, addr_valid);
        end
        send_a(9'd1, 8'd0, 9'd1);
        step();
        compares++;
        if (addr_valid !== 1'b1 || addr !== 17'd1 || addr_last !== 1'b1) begin
            errs++;
            $display("FAIL midrun_new got v=%b a=%0d l=%b want 1 1 1", addr_valid, addr, addr_last);
        end
        step();
        compares++;
        if (addr_valid !== 1'b0) begin
            errs++;
            $display("FAIL midrun_new_done got v=%b want 0", addr_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_x = 9'd0; req_y = 8'd0; req_len = 9'd0; addr_ready = 1'b1;
        req_valid_b = 1'b0; req_x_b = 10'd0; req_y_b = 9'd0; req_len_b = 10'd0; addr_ready_b = 1'b1;
        req_valid_c = 1'b0; req_x_c = 7'd0; req_y_c = 7'd0; req_len_c = 7'd0; addr_ready_c = 1'b1;
        test_reset();
        test_defaults();
        test_truncate();
        test_drop(9'd5, 8'd240);
        test_drop(9'd320, 8'd5);
        test_backpressure();
        test_resolutions();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
        $finish;
    end

endmodule
